// File: rtl/sub_serial_pkg.sv
// Shared types and elaboration helpers for the chunk-serial subtractor.
package sub_serial_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  function automatic int nchunk(input int n, input int w);
    return n / w;
  endfunction

  // Chunk counter width; a one-chunk operation still gets a 1-bit counter.
  function automatic int cnt_width(input int n, input int w);
    return (n / w > 1) ? $clog2(n / w) : 1;
  endfunction

endpackage

// File: rtl/sub_serial_if.sv
// Operand and result handshake bundle of sub_serial.
// valid/ready: a transfer happens on a rising clk edge where valid & ready are both 1;
// the sender holds valid and its data stable until that edge, ready may change freely.
interface sub_serial_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bi;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] d;
  logic         bo;

  modport master (
    output in_valid, a, b, bi, out_ready,
    input  in_ready, out_valid, d, bo
  );

  modport slave (
    input  in_valid, a, b, bi, out_ready,
    output in_ready, out_valid, d, bo
  );
endinterface

// File: rtl/adder_rca.sv
// Plain N-bit ripple-carry adder: {co, s} = a + b + ci.
module adder_rca #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic [N:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < N; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[N];
  end

endmodule

// File: rtl/sub_serial.sv
// Multi-cycle subtractor d = a - b - bi (mod 2**N), W bits per clock, LSB chunk first,
// built from one W-bit ripple adder computing a + ~b + ~bi.
module sub_serial
  import sub_serial_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  sub_serial_if.slave bus,
  output sub_state_t dbg_state
);

  localparam int NCH = nchunk(N, W);
  localparam int CW  = cnt_width(N, W);
  localparam logic [CW-1:0] K_LAST = CW'(NCH - 1);

  if (W < 1 || W > N || (N % W) != 0) begin : g_bad_param
    $fatal(1, "sub_serial: N must be a positive multiple of W");
  end

  sub_state_t    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  nb_q, nb_d;
  logic [N-1:0]  d_q, d_d;
  logic          c_q, c_d;
  logic          bo_q, bo_d;
  logic [CW-1:0] k_q, k_d;

  logic          accept;
  logic          last_chunk;
  logic [W-1:0]  sum;
  logic          co;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.in_valid) state_d = BUSY;
      BUSY: if (last_chunk)   state_d = DONE;
      DONE: if (bus.out_ready) state_d = bus.in_valid ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    bus.out_valid = (state_q == DONE);
    dbg_state     = state_q;
  end

  assign accept     = bus.in_valid & bus.in_ready;
  assign last_chunk = (state_q == BUSY) & (k_q == K_LAST);

  // Operands shift right one chunk per BUSY cycle, so the adder always sees bits [W-1:0].
  adder_rca #(.N(W)) u_add (
    .a  (a_q[W-1:0]),
    .b  (nb_q[W-1:0]),
    .ci (c_q),
    .s  (sum),
    .co (co)
  );

  always_comb begin
    a_d  = a_q;
    nb_d = nb_q;
    d_d  = d_q;
    c_d  = c_q;
    bo_d = bo_q;
    k_d  = k_q;
    if (accept) begin
      a_d  = bus.a;
      nb_d = ~bus.b;
      c_d  = ~bus.bi;
      k_d  = '0;
    end else if (state_q == BUSY) begin
      a_d  = a_q >> W;
      nb_d = nb_q >> W;
      // Result chunks enter at the top; after NCH shifts chunk 0 sits at the LSB.
      d_d  = (d_q >> W) | (N'(sum) << (N - W));
      c_d  = co;
      if (k_q != K_LAST) k_d = k_q + CW'(1);
      if (last_chunk)    bo_d = ~co;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q  <= '0;
      nb_q <= '0;
      d_q  <= '0;
      c_q  <= 1'b0;
      bo_q <= 1'b0;
      k_q  <= '0;
    end else begin
      a_q  <= a_d;
      nb_q <= nb_d;
      d_q  <= d_d;
      c_q  <= c_d;
      bo_q <= bo_d;
      k_q  <= k_d;
    end
  end

  assign bus.d  = d_q;
  assign bus.bo = bo_q;

endmodule
